// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Instruction-memory port of the fetch stage: a request channel (address with
// valid/ready) and a response channel (data with valid only, no back-pressure).
//
// Handshake semantics:
//   - A request transfers on a clk edge where imem_req_valid && imem_req_ready.
//     While valid is high and ready is low, the request is NOT committed; the
//     memory must treat it as abortable, and the fetch unit may drop valid or
//     change imem_addr only because of a redirect.
//   - At most one request is outstanding. Exactly one response cycle
//     (imem_resp_valid=1 for one clk) follows every accepted request, after any
//     latency of at least one cycle. The response channel cannot be stalled.
//
// Signals:
//   imem_req_valid   master->slave  request valid
//   imem_req_ready   slave->master  request accepted this cycle
//   imem_addr        master->slave  fetch address (DATA_WIDTH)
//   imem_resp_valid  slave->master  response data valid
//   imem_resp_data   slave->master  fetched instruction word (DATA_WIDTH)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;

    // Fetch unit side.
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    // Instruction memory side.
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC, fetches one instruction at a time from
// instruction memory and presents the {instrF, PCF, PCPlus4F, validF} bundle to
// the IF/ID pipeline register.
//
//   - Holds the bundle unchanged while decode stalls (stallF=1).
//   - Redirects to PCTargetE when Execute resolves a taken branch/jump
//     (PCSrcE=1); any wrong-path fetch in flight is discarded.
//   - Drives a NOP bubble (validF=0, instrF=NOP_INSTR) whenever decode is
//     ready and no new instruction is loaded.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stallF          decode cannot accept a new bundle; hold outputs
//   PCSrcE          redirect request from Execute
//   PCTargetE       redirect target
//   imem            instruction-memory port (fetch_unit_if.master)
//   instrF          instruction to IF/ID (registered)
//   PCF             PC of instrF (registered)
//   PCPlus4F        PCF+4, modulo 2^DATA_WIDTH (registered)
//   validF          bundle holds a real instruction (registered)
//   state_dbg       current FSM state, for debug/checkers
//                   (0=REQ, 1=WAIT, 2=HOLD)
//
// Throughput is one instruction every two cycles with a zero-wait memory,
// because only one request is ever outstanding.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      RESET_PC   = DATA_WIDTH'(32'h0000_0000),
    parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    fetch_unit_if.master          imem,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF,
    output logic [1:0]            state_dbg
);

    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    // REQ : request at pc_q is presented to memory
    // WAIT: one request accepted, waiting for its response
    // HOLD: response arrived while decode was stalled on a valid bundle;
    //       it sits in the hold buffer until decode frees up
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Fetch bookkeeping.
    logic [DATA_WIDTH-1:0] pc_q, pc_d;          // next address to request
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;  // address of outstanding request
    logic                  kill_q, kill_d;      // outstanding response is wrong-path

    // Hold buffer: one instruction parked while decode is stalled.
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;

    // Output bundle registers.
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;

    logic                  accept;
    logic                  bundle_free;
    logic                  loaded;
    logic [DATA_WIDTH-1:0] req_pc_plus4;
    logic [DATA_WIDTH-1:0] hold_pc_plus4;

    // ------------------------------------------------------------------
    // Memory request side. The request is combinational from the state so
    // that a redirect in REQ immediately changes the presented address
    // on the following cycle without an extra bubble.
    // ------------------------------------------------------------------
    assign imem.imem_req_valid = (state_q == REQ) && !rst;
    assign imem.imem_addr      = pc_q;

    assign accept        = imem.imem_req_valid && imem.imem_req_ready;

    // Decode can take a new bundle if it is not stalling, or if the bundle
    // it is stalling on is only a bubble.
    assign bundle_free   = !stallF || !valid_q;

    // Wraps naturally modulo 2^DATA_WIDTH; no alignment check.
    assign req_pc_plus4  = req_pc_q + FOUR;
    assign hold_pc_plus4 = hold_pc_q + FOUR;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pcf_q        <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcf_q        <= pcf_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and bundle logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pcf_d        = pcf_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        loaded       = 1'b0;

        case (state_q)
            REQ: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (imem.imem_resp_valid) begin
                    if (kill_q) begin
                        // Wrong-path data: drop it and fetch from pc_q,
                        // which already holds the redirect target.
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (bundle_free) begin
                        instr_d = imem.imem_resp_data;
                        pcf_d   = req_pc_q;
                        pc4_d   = req_pc_plus4;
                        valid_d = 1'b1;
                        loaded  = 1'b1;
                        pc_d    = req_pc_plus4;
                        state_d = REQ;
                    end else begin
                        hold_instr_d = imem.imem_resp_data;
                        hold_pc_d    = req_pc_q;
                        pc_d         = req_pc_plus4;
                        state_d      = HOLD;
                    end
                end
            end

            HOLD: begin
                if (!stallF) begin
                    instr_d = hold_instr_q;
                    pcf_d   = hold_pc_q;
                    pc4_d   = hold_pc_plus4;
                    valid_d = 1'b1;
                    loaded  = 1'b1;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase

        // Bubble: decode is taking a bundle but nothing new arrived.
        // PCF/PCPlus4F deliberately keep their last value.
        if (!stallF && !loaded) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        // Redirect overrides stall, response and hold. Whatever the case
        // statement loaded into the bundle this cycle is wrong-path.
        if (PCSrcE) begin
            pc_d         = PCTargetE;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            pcf_d        = pcf_q;
            pc4_d        = pc4_q;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            case (state_q)
                REQ: begin
                    // A request accepted this same cycle fetched the old
                    // address; its response must be thrown away.
                    if (accept) begin
                        kill_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    state_d = REQ;
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instrF    = instr_q;
    assign PCF       = pcf_q;
    assign PCPlus4F  = pc4_q;
    assign validF    = valid_q;
    assign state_dbg = state_q;

endmodule
